bcd_counter_display: RTL and testbench



---
 rtl/counter_pkg.sv | 38 +++
 rtl/bcd_digit.sv | 38 +++
 rtl/bcd_counter_display.sv | 96 +++++++++
 tb/tb_bcd_counter_display.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants for the BCD counter display: digit count, scan divider
// default and active-low seven-segment patterns (gfedcba).
package counter_pkg;

    localparam int NUM_DIGITS   = 4;
    localparam int SCAN_DIV_DEF = 100000;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit (0-9) with increment/decrement, clear, and
// combinational carry/borrow out for chaining into the next digit.
module bcd_digit (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [3:0] digit_o,
    output logic       carry_o,
    output logic       borrow_o
);

    logic [3:0] digit_q, digit_d;

    always_comb begin
        digit_d = digit_q;
        if (clr_i)
            digit_d = 4'd0;
        else if (inc_i)
            digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
        else if (dec_i)
            digit_d = (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            digit_q <= 4'd0;
        else
            digit_q <= digit_d;
    end

    // Carry/borrow only ripple while this digit is actually stepping.
    assign carry_o  = inc_i & (digit_q == 4'd9);
    assign borrow_o = dec_i & (digit_q == 4'd0);
    assign digit_o  = digit_q;

endmodule

// File: rtl/bcd_counter_display.sv
// Four-digit BCD up/down counter advanced by rising edges of the slow clk_1s
// level, shown on a multiplexed common-anode seven-segment display.
module bcd_counter_display
    import counter_pkg::*;
#(
    parameter int SCAN_DIV = SCAN_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_1s,
    input  logic       en,
    input  logic       up_down,
    input  logic       clr,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    // Edge detector; both stages reset high so a level already high at
    // reset release is not mistaken for a rising edge.
    logic s1_q, s2_q, tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= clk_1s;
            s2_q <= s1_q;
        end
    end

    assign tick = s1_q & ~s2_q;

    logic [NUM_DIGITS:0]           inc_c, dec_c;
    logic [NUM_DIGITS-1:0][3:0]    digit_w;
    logic                          wrap_unused;

    assign inc_c[0] = tick & en & up_down;
    assign dec_c[0] = tick & en & ~up_down;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk_i    (clk),
            .rst_i    (rst),
            .clr_i    (clr),
            .inc_i    (inc_c[i]),
            .dec_i    (dec_c[i]),
            .digit_o  (digit_w[i]),
            .carry_o  (inc_c[i+1]),
            .borrow_o (dec_c[i+1])
        );
    end

    // Wrap out of the top digit needs no action: all digits already rolled.
    assign wrap_unused = inc_c[NUM_DIGITS] | dec_c[NUM_DIGITS];

    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]    sel_q, sel_d;

    always_comb begin
        scan_cnt_d = scan_cnt_q + SW'(1);
        sel_d      = sel_q;
        if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            sel_d      = sel_q + 2'd1;
        end
    end

    logic [6:0] seg_q, seg_d;
    logic [3:0] an_q, an_d;

    assign seg_d = seg_decode(digit_w[sel_q]);
    assign an_d  = ~(4'b0001 << sel_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_q <= '0;
            sel_q      <= 2'd0;
            seg_q      <= SEG_0;
            an_q       <= 4'b1110;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            sel_q      <= sel_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = 1'b1;

endmodule

// File: tb/tb_bcd_counter_display.sv
// Directed bench for bcd_counter_display with SCAN_DIV=4; the count is read
// back only through the scanned seg/an outputs.
module tb_bcd_counter_display;

    localparam int SD = 4;

    logic       clk = 1'b0;
    logic       rst, clk_1s, en, up_down, clr;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    int errors = 0;
    int checks = 0;

    bcd_counter_display #(.SCAN_DIV(SD)) dut (
        .clk(clk), .rst(rst), .clk_1s(clk_1s), .en(en), .up_down(up_down),
        .clr(clr), .seg(seg), .an(an), .dp(dp)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] pat(input int d);
        logic [6:0] t [10];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return t[d];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One clk_1s period: high 3 cycles, low 3 cycles.
    task automatic pulse();
        clk_1s = 1'b1; cycles(3);
        clk_1s = 1'b0; cycles(3);
    endtask

    // Observe a full refresh and compare all four digits against val (d3..d0).
    task automatic expect_display(input string tag, input int val);
        logic [27:0] got, exp;
        logic [3:0]  seen;
        got = '1; seen = '0;
        for (int c = 0; c < 4*SD + 2; c++) begin
            @(negedge clk);
            case (an)
                4'b1110: begin got[6:0]   = seg; seen[0] = 1'b1; end
                4'b1101: begin got[13:7]  = seg; seen[1] = 1'b1; end
                4'b1011: begin got[20:14] = seg; seen[2] = 1'b1; end
                4'b0111: begin got[27:21] = seg; seen[3] = 1'b1; end
                default: seen = seen;
            endcase
        end
        exp = {pat((val/1000)%10), pat((val/100)%10), pat((val/10)%10), pat(val%10)};
        check({tag, "_anseen"}, {28'd0, seen}, 32'hF);
        check(tag, {4'd0, got}, {4'd0, exp});
    endtask

    initial begin
        logic [3:0] seq [4];
        int n;
        rst = 1'b1; clk_1s = 1'b0; en = 1'b0; up_down = 1'b1; clr = 1'b0;

        // 1: reset
        cycles(2);
        rst = 1'b0;
        @(negedge clk);
        check("rst_an",  {28'd0, an}, 32'hE);
        check("rst_seg", {25'd0, seg}, {25'd0, 7'b1000000});
        check("rst_dp",  {31'd0, dp}, 32'd1);
        expect_display("rst_count", 0);

        // 2: count up 12
        en = 1'b1; up_down = 1'b1;
        repeat (12) pulse();
        expect_display("up12", 12);
        n = 0;
        while (an != 4'b1101 && n < 20) begin @(negedge clk); n++; end
        check("up12_tens_seg", {25'd0, seg}, {25'd0, 7'b1111001});
        n = 0;
        while (an != 4'b1110 && n < 20) begin @(negedge clk); n++; end
        check("up12_ones_seg", {25'd0, seg}, {25'd0, 7'b0100100});

        // 3: wrap down and back up
        clr = 1'b1; cycles(1); clr = 1'b0;
        expect_display("clr0", 0);
        up_down = 1'b0; pulse();
        expect_display("down_wrap", 9999);
        up_down = 1'b1; pulse();
        expect_display("up_wrap", 0);

        // 4: enable hold, then clear wins over a coincident tick
        repeat (7) pulse();
        en = 1'b0;
        repeat (3) pulse();
        expect_display("en_hold", 7);
        en = 1'b1;
        clr = 1'b1; clk_1s = 1'b1;
        cycles(2);
        clr = 1'b0;
        cycles(1);
        clk_1s = 1'b0; cycles(3);
        expect_display("clr_vs_tick", 0);

        // 5: scan sequence and dwell
        seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        n = 0;
        while (an != 4'b1110 && n < 20) begin @(negedge clk); n++; end
        n = 0;
        while (an != 4'b1101 && n < 20) begin @(negedge clk); n++; end
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (an == seq[k] && n < 20) begin @(negedge clk); n++; end
            check($sformatf("scan_dwell_%0d", k), n, SD);
        end

        // 6: clk_1s high through reset release gives no tick
        clk_1s = 1'b1; rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(10);
        expect_display("hi_at_release", 0);
        clk_1s = 1'b0; cycles(3);
        clk_1s = 1'b1; cycles(3);
        clk_1s = 1'b0; cycles(3);
        expect_display("first_edge", 1);
        repeat (41) pulse();
        expect_display("count42", 42);
        while (an == 4'b1110) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_an",  {28'd0, an}, 32'hE);
        check("midrst_seg", {25'd0, seg}, {25'd0, 7'b1000000});
        @(negedge clk);
        rst = 1'b0;
        expect_display("midrst_count", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
